// File: rtl/backend_cmd_tx.sv
// Serial command framer: one line per backend channel, fixed-length MSB-first frames.
// Define BACKEND_CMD_TT_EN to insert an all-channel TT frame every TT_PERIOD frames.

module backend_cmd_lane #(
  parameter int                   CODE_BITS = 4,
  parameter logic [CODE_BITS-1:0] IDLE_CODE = 4'b1010
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 soft_rst,
  input  logic                 load_i,
  input  logic [CODE_BITS-1:0] code_i,
  output logic                 line_o
);
  logic [CODE_BITS-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[CODE_BITS-2:0], 1'b0};
    if (load_i) sh_d = code_i;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)        sh_q <= IDLE_CODE;
    else if (soft_rst) sh_q <= IDLE_CODE;
    else               sh_q <= sh_d;
  end

  assign line_o = sh_q[CODE_BITS-1];
endmodule

module backend_cmd_tx #(
  parameter int                   NBACKEND  = 4,
  parameter int                   CODE_BITS = 4,
  parameter logic [CODE_BITS-1:0] IDLE_CODE = 4'b1010,
  parameter logic [CODE_BITS-1:0] RST_CODE  = 4'b1100,
  parameter logic [CODE_BITS-1:0] TT_CODE   = 4'b1110,
  parameter logic [CODE_BITS-1:0] USER_CODE = 4'b1001,
  parameter int                   TT_PERIOD = 1024
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                soft_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_sel,
  input  logic [NBACKEND-1:0] cmd_mask,
  output logic                cmd_done,
  output logic                frame_strobe,
  output logic [NBACKEND-1:0] m_cmd,
  output logic [15:0]         cmd_count
);
  localparam int CW = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;

  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                pending_q, pending_d;
  logic [1:0]          psel_q, psel_d;
  logic [NBACKEND-1:0] pmask_q, pmask_d;
  logic                done_q, done_d;
  logic                strobe_q, strobe_d;
  logic [15:0]         count_q, count_d;

  logic                boundary, accept, launch_cmd, launch_tt;
  logic [CODE_BITS-1:0] sel_code;
  logic [NBACKEND-1:0][CODE_BITS-1:0] lane_code;

  assign boundary   = (bit_cnt_q == '0);
  assign accept     = cmd_valid && !pending_q;
  assign launch_cmd = boundary && pending_q;

  always_comb begin
    sel_code = IDLE_CODE;
    case (psel_q)
      2'd0:    sel_code = RST_CODE;
      2'd1:    sel_code = TT_CODE;
      2'd2:    sel_code = USER_CODE;
      default: sel_code = IDLE_CODE;
    endcase
  end

`ifdef BACKEND_CMD_TT_EN
  localparam int FW = (TT_PERIOD > 2) ? $clog2(TT_PERIOD) : 1;

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          tt_due_q, tt_due_d;

  // A pending command wins the boundary; tt_due just waits while frame_cnt keeps running.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    tt_due_d    = tt_due_q;
    launch_tt   = boundary && !pending_q && tt_due_q;
    if (launch_tt) tt_due_d = 1'b0;
    if (boundary) begin
      if (frame_cnt_q == FW'(TT_PERIOD-1)) begin
        frame_cnt_d = '0;
        tt_due_d    = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      tt_due_q    <= 1'b0;
    end else if (soft_rst) begin
      frame_cnt_q <= '0;
      tt_due_q    <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      tt_due_q    <= tt_due_d;
    end
  end
`else
  // No automatic TT; TT only goes out through cmd_sel=1.
  assign launch_tt = 1'b0 & (TT_PERIOD > 1);
`endif

  always_comb begin
    bit_cnt_d = boundary ? CW'(CODE_BITS-1) : bit_cnt_q - 1'b1;
    pending_d = pending_q;
    psel_d    = psel_q;
    pmask_d   = pmask_q;
    count_d   = count_q;
    done_d    = launch_cmd;
    strobe_d  = boundary;
    if (launch_cmd) begin
      pending_d = 1'b0;
      count_d   = count_q + 16'd1;
    end
    if (accept) begin
      pending_d = 1'b1;
      psel_d    = cmd_sel;
      pmask_d   = cmd_mask;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= CW'(CODE_BITS-1);
      pending_q <= 1'b0;
      psel_q    <= 2'd0;
      pmask_q   <= '0;
      done_q    <= 1'b0;
      strobe_q  <= 1'b0;
      count_q   <= '0;
    end else if (soft_rst) begin
      bit_cnt_q <= CW'(CODE_BITS-1);
      pending_q <= 1'b0;
      psel_q    <= 2'd0;
      pmask_q   <= '0;
      done_q    <= 1'b0;
      strobe_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      psel_q    <= psel_d;
      pmask_q   <= pmask_d;
      done_q    <= done_d;
      strobe_q  <= strobe_d;
      count_q   <= count_d;
    end
  end

  for (genvar i = 0; i < NBACKEND; i++) begin : g_lane
    assign lane_code[i] = launch_cmd ? (pmask_q[i] ? sel_code : IDLE_CODE)
                        : (launch_tt ? TT_CODE : IDLE_CODE);
    backend_cmd_lane #(
      .CODE_BITS (CODE_BITS),
      .IDLE_CODE (IDLE_CODE)
    ) u_lane (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .soft_rst (soft_rst),
      .load_i   (boundary),
      .code_i   (lane_code[i]),
      .line_o   (m_cmd[i])
    );
  end

  assign cmd_ready    = ~pending_q;
  assign cmd_done     = done_q;
  assign frame_strobe = strobe_q;
  assign cmd_count    = count_q;
endmodule

// File: tb/tb_backend_cmd_tx.sv
// Self-checking bench for backend_cmd_tx: frame-level reference model plus directed literals.
module tb_backend_cmd_tx;
  localparam int NB = 4;
  localparam int CB = 4;
  localparam logic [CB-1:0] IDLE = 4'b1010;
  localparam logic [CB-1:0] RSTC = 4'b1100;
  localparam logic [CB-1:0] TTC  = 4'b1110;
  localparam logic [CB-1:0] USER = 4'b1001;
`ifdef BACKEND_CMD_TT_EN
  localparam int TTP = 8;
  localparam bit TT_ON = 1'b1;
`else
  localparam int TTP = 1024;
  localparam bit TT_ON = 1'b0;
`endif

  typedef logic [NB-1:0][CB-1:0] frame_t;
  typedef struct { logic [1:0] sel; logic [NB-1:0] mask; } cmd_t;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          soft_rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_sel = 2'd0;
  logic [NB-1:0] cmd_mask = '0;
  logic          cmd_done, frame_strobe;
  logic [NB-1:0] m_cmd;
  logic [15:0]   cmd_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  backend_cmd_tx #(.NBACKEND(NB), .CODE_BITS(CB), .TT_PERIOD(TTP)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_mask(cmd_mask), .cmd_done(cmd_done), .frame_strobe(frame_strobe),
    .m_cmd(m_cmd), .cmd_count(cmd_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frames, phase = cycles since reset mod CB
  frame_t      mcode;
  int          mcyc, mnb;
  bit          mtt, mdone, mstrobe, mrdy, mbnd;
  logic [15:0] mcount;
  cmd_t        mpend[$];
  cmd_t        mc;

  function automatic logic [CB-1:0] code_of(input logic [1:0] s);
    case (s)
      2'd0: return RSTC;
      2'd1: return TTC;
      2'd2: return USER;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) mcode[i] = IDLE;
    mcyc = 0; mnb = 0; mtt = 0; mdone = 0; mstrobe = 0; mcount = '0;
    mpend.delete();
  endtask

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n || soft_rst) model_reset();
    else begin
      mrdy = (mpend.size() == 0);
      mbnd = ((mcyc % CB) == CB-1);
      mdone = 0;
      mstrobe = mbnd;
      if (mbnd) begin
        mnb++;
        if (mpend.size() > 0) begin
          mc = mpend.pop_front();
          for (int i = 0; i < NB; i++) mcode[i] = mc.mask[i] ? code_of(mc.sel) : IDLE;
          mcount++;
          mdone = 1;
        end else if (mtt) begin
          for (int i = 0; i < NB; i++) mcode[i] = TTC;
          mtt = 0;
        end else begin
          for (int i = 0; i < NB; i++) mcode[i] = IDLE;
        end
        if (TT_ON && (mnb % TTP) == 0) mtt = 1;
      end
      if (cmd_valid && mrdy) begin
        mc.sel = cmd_sel; mc.mask = cmd_mask;
        mpend.push_back(mc);
      end
      mcyc++;
    end
  end

  logic [NB-1:0] exp_m;
  always @(negedge sys_clk) begin
    if (chk_en) begin
      for (int i = 0; i < NB; i++) exp_m[i] = mcode[i][CB-1-(mcyc % CB)];
      chk("m_cmd", 32'(m_cmd), 32'(exp_m));
      chk("cmd_ready", 32'(cmd_ready), 32'(mpend.size() == 0));
      chk("cmd_done", 32'(cmd_done), 32'(mdone));
      chk("frame_strobe", 32'(frame_strobe), 32'(mstrobe));
      chk("cmd_count", 32'(cmd_count), 32'(mcount));
    end
  end

  // ---------------- helpers
  task automatic wait_strobe();
    int n = 0;
    while (!frame_strobe && n < 4*CB) begin @(negedge sys_clk); n++; end
    if (!frame_strobe) chk("strobe_timeout", 32'(frame_strobe), 32'd1);
  endtask

  task automatic capture(input bit fresh, output frame_t fr, output bit dn);
    if (fresh) @(negedge sys_clk);
    wait_strobe();
    dn = cmd_done;
    for (int b = 0; b < CB; b++) begin
      for (int i = 0; i < NB; i++) fr[i][CB-1-b] = m_cmd[i];
      @(negedge sys_clk);
    end
  endtask

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic soft_pulse();
    step(); soft_rst = 1'b1;
    step(); soft_rst = 1'b0;
  endtask

  function automatic logic [CB-1:0] s8_exp(input int k);
    if (k == 17) return USER;
    if (TT_ON && (k == 9 || k == 18 || k == 25)) return TTC;
    return IDLE;
  endfunction

  frame_t fr;
  bit     dn;
  int     n, acc, ndone;
  logic [CB-1:0] ec;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    // reset state
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_count", 32'(cmd_count), 32'd0);
    chk("rst_lines", 32'(m_cmd), 32'hF);
    chk("rst_strobe", 32'(frame_strobe), 32'd0);

    // idle frame, then RST on lanes 0 and 2 accepted mid-frame
    capture(1'b1, fr, dn);
    chk("idle_frame", 32'(fr), 32'hAAAA);
    chk("idle_done", 32'(dn), 32'd0);
    step(); cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_mask = 4'b0101;
    step(); cmd_valid = 1'b0;
    chk("ready_low", 32'(cmd_ready), 32'd0);
    capture(1'b0, fr, dn);
    chk("rst_frame", 32'(fr), 32'hAC_AC);
    chk("rst_done", 32'(dn), 32'd1);
    chk("rst_cnt1", 32'(cmd_count), 32'd1);
    chk("rst_ready_back", 32'(cmd_ready), 32'd1);

    // back-to-back USER commands
    soft_pulse();
    fork
      begin
        cmd_valid = 1'b1; cmd_sel = 2'd2; cmd_mask = 4'hF; acc = 0; n = 0;
        while (acc < 3 && n < 20*CB) begin
          @(negedge sys_clk); n++;
          if (cmd_ready) acc++;
        end
        step(); cmd_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd3);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          capture(k == 0, fr, dn);
          chk("b2b_frame", 32'(fr), 32'h9999);
          chk("b2b_done", 32'(dn), 32'd1);
        end
      end
    join
    chk("b2b_count", 32'(cmd_count), 32'd3);

    // accept on a boundary cycle: skips that boundary
    @(negedge sys_clk); wait_strobe();
    repeat (3) @(posedge sys_clk);
    #1 cmd_valid = 1'b1; cmd_sel = 2'd1; cmd_mask = 4'b1000;
    step(); cmd_valid = 1'b0;
    n = 0;
    while (n < 4*CB) begin
      @(negedge sys_clk); n++;
      if (cmd_done) break;
    end
    chk("bnd_latency", 32'(n), 32'(CB+1));

    // soft reset with a command pending, line showing 0
    @(negedge sys_clk); wait_strobe();
    cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_mask = 4'hF;
    step(); cmd_valid = 1'b0; soft_rst = 1'b1;
    step(); soft_rst = 1'b0;
    chk("srst_lines", 32'(m_cmd), 32'hF);
    chk("srst_ready", 32'(cmd_ready), 32'd1);
    chk("srst_count", 32'(cmd_count), 32'd0);
    ndone = 0;
    repeat (3*CB) begin @(negedge sys_clk); if (cmd_done) ndone++; end
    chk("srst_nodone", 32'(ndone), 32'd0);

    // async reset, same situation
    @(negedge sys_clk); wait_strobe();
    cmd_valid = 1'b1; cmd_sel = 2'd0; cmd_mask = 4'hF;
    step(); cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lines", 32'(m_cmd), 32'hF);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_count", 32'(cmd_count), 32'd0);
    step(); rst_n = 1'b1;
    ndone = 0;
    repeat (3*CB) begin @(negedge sys_clk); if (cmd_done) ndone++; end
    chk("arst_nodone", 32'(ndone), 32'd0);

    // randomized traffic against the model
    repeat (600) begin
      step();
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_sel   = 2'($urandom_range(0, 3));
      cmd_mask  = NB'($urandom);
      soft_rst  = ($urandom_range(0, 99) == 0);
    end
    step(); cmd_valid = 1'b0; soft_rst = 1'b0;

    // periodic TT with a command occupying the due boundary
    soft_pulse();
    fork
      begin
        repeat (64) @(posedge sys_clk);
        #1 cmd_valid = 1'b1; cmd_sel = 2'd2; cmd_mask = 4'hF;
        step(); cmd_valid = 1'b0;
      end
      begin
        for (int k = 1; k <= 25; k++) begin
          capture(k == 1, fr, dn);
          ec = s8_exp(k);
          chk($sformatf("tt_frame%0d", k), 32'(fr), 32'({NB{ec}}));
          chk($sformatf("tt_done%0d", k), 32'(dn), 32'(k == 17));
        end
      end
    join
    chk("tt_count", 32'(cmd_count), 32'd1);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
